// File: rtl/clk_div_pkg.sv
// Shared types and constants for the core clock-enable controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DRAIN,
        LOAD
    } clkdiv_state_t;

    localparam int unsigned MIN_DIV = 1;

endpackage

// File: rtl/tick_counter.sv
// Down-counter with synchronous load, count enable and zero flag.
// Reloads from reload_val_i when it reaches zero, so it never underflows.
module tick_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] reload_val_i,
    output logic             zero_c_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign zero_c_o = (cnt_q == '0);

    // Load has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = zero_c_o ? reload_val_i : cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Core clock-enable controller: periodic tick, 50% phase level, core reset
// sequencing and tick-aligned divisor changes via a valid/ready handshake.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DEF_DIV   = 127,
    parameter int unsigned RST_TICKS = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             phase,
    output logic             core_resetn,
    output logic [DIV_W-1:0] cur_div
);

    localparam int unsigned HOLD_W = $clog2(RST_TICKS + 1);

    clkdiv_state_t     state_q, state_d;
    logic [DIV_W-1:0]  cur_div_q, cur_div_d;
    logic [DIV_W-1:0]  pend_div_q, pend_div_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              tick_q, tick_d;
    logic              phase_q, phase_d;
    logic              core_resetn_q, core_resetn_d;

    logic cnt_en;
    logic cnt_zero;
    logic tick_fire;

    // Counting pauses for the single LOAD bubble and whenever run_en is low
    assign cnt_en    = run_en && (state_q != LOAD);
    assign tick_fire = cnt_en && cnt_zero;

    tick_counter #(
        .WIDTH   (DIV_W),
        .RST_VAL (DIV_W'(DEF_DIV))
    ) u_tick_counter (
        .clk          (CLK),
        .rst_n        (RESETn),
        .en_i         (cnt_en),
        .load_i       (state_q == LOAD),
        .load_val_i   (pend_div_q),
        .reload_val_i (cur_div_q),
        .zero_c_o     (cnt_zero)
    );

    always_comb begin
        state_d       = state_q;
        cur_div_d     = cur_div_q;
        pend_div_d    = pend_div_q;
        hold_cnt_d    = hold_cnt_q;
        tick_d        = 1'b0;
        phase_d       = phase_q;
        core_resetn_d = core_resetn_q;

        if (tick_fire) begin
            tick_d  = 1'b1;
            phase_d = ~phase_q;
        end

        case (state_q)
            HOLD: begin
                if (tick_fire) begin
                    if (hold_cnt_q == HOLD_W'(RST_TICKS - 1)) begin
                        state_d       = RUN;
                        core_resetn_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            RUN: begin
                if (cfg_valid) begin
                    pend_div_d = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (tick_fire) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cur_div_d = pend_div_q;
                state_d   = RUN;
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= HOLD;
            cur_div_q     <= DIV_W'(DEF_DIV);
            pend_div_q    <= '0;
            hold_cnt_q    <= '0;
            tick_q        <= 1'b0;
            phase_q       <= 1'b0;
            core_resetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_div_q     <= cur_div_d;
            pend_div_q    <= pend_div_d;
            hold_cnt_q    <= hold_cnt_d;
            tick_q        <= tick_d;
            phase_q       <= phase_d;
            core_resetn_q <= core_resetn_d;
        end
    end

    assign cfg_ready   = (state_q == RUN);
    assign tick        = tick_q;
    assign phase       = phase_q;
    assign core_resetn = core_resetn_q;
    assign cur_div     = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus a randomized
// run, all compared against a period-counting reference model.
module tb_clk_div_ctrl;

    localparam int DW  = 8;
    localparam int DEF = 3;
    localparam int RTK = 2;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          run_en;
    logic          cfg_valid;
    logic [DW-1:0] cfg_div;
    logic          cfg_ready;
    logic          tick;
    logic          phase;
    logic          core_resetn;
    logic [DW-1:0] cur_div;

    int errors = 0;
    int checks = 0;

    clk_div_ctrl #(
        .DIV_W     (DW),
        .DEF_DIV   (DEF),
        .RST_TICKS (RTK)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .run_en      (run_en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .tick        (tick),
        .phase       (phase),
        .core_resetn (core_resetn),
        .cur_div     (cur_div)
    );

    always #5 CLK = ~CLK;

    // Reference model: elapsed enabled cycles since the last tick/reload,
    // ticks seen while the core is held, and a queue of accepted divisors.
    int  m_elapsed;
    int  m_cur;
    bit  m_phase;
    bit  m_tick;
    int  m_rticks;
    bit  m_released;
    bit  m_bubble;
    bit  last_acc;
    int  m_pend[$];

    task automatic model_reset();
        m_elapsed  = 0;
        m_cur      = DEF;
        m_phase    = 1'b0;
        m_tick     = 1'b0;
        m_rticks   = 0;
        m_released = 1'b0;
        m_bubble   = 1'b0;
        last_acc   = 1'b0;
        m_pend.delete();
    endtask

    function automatic bit m_ready();
        return m_released && (m_pend.size() == 0);
    endfunction

    task automatic model_step(input bit run, input bit valid, input int div);
        bit ready;
        bit counting;
        bit fire;
        ready    = m_ready();
        counting = run && !m_bubble;
        fire     = counting && (m_elapsed == m_cur);
        m_tick   = fire;
        if (m_bubble) begin
            m_cur     = m_pend.pop_front();
            m_elapsed = 0;
            m_bubble  = 1'b0;
        end else if (fire) begin
            m_phase   = ~m_phase;
            m_elapsed = 0;
            if (!m_released) begin
                m_rticks++;
                if (m_rticks == RTK) m_released = 1'b1;
            end else if (m_pend.size() > 0) begin
                m_bubble = 1'b1;
            end
        end else if (counting) begin
            m_elapsed++;
        end
        last_acc = ready && valid;
        if (last_acc) m_pend.push_back((div == 0) ? 1 : div);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check ready, step model at posedge, check outputs.
    task automatic do_cycle(input bit run, input bit valid, input int div);
        run_en    = run;
        cfg_valid = valid;
        cfg_div   = DW'(div);
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        @(posedge CLK);
        model_step(run, valid, div);
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("core_resetn", 32'(core_resetn), 32'(m_released));
        chk("cur_div", 32'(cur_div), 32'(m_cur));
        @(negedge CLK);
    endtask

    task automatic offer_div(input int d);
        int n;
        n = 0;
        do begin
            do_cycle(1'b1, 1'b1, d);
            n++;
        end while (!last_acc && n < 1000);
        chk("offer_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic settle(input int exp_div);
        int n;
        n = 0;
        while (m_pend.size() != 0 && n < 1000) begin
            do_cycle(1'b1, 1'b0, 0);
            n++;
        end
        chk("settled_cur_div", 32'(cur_div), 32'(exp_div));
    endtask

    task automatic measure_gap(output int gap);
        int n;
        gap = -1;
        n   = 0;
        while (tick !== 1'b1 && n < 600) begin
            do_cycle(1'b1, 1'b0, 0);
            n++;
        end
        if (tick === 1'b1) begin
            n = 0;
            do begin
                do_cycle(1'b1, 1'b0, 0);
                n++;
            end while (tick !== 1'b1 && n < 600);
            if (tick === 1'b1) gap = n;
        end
    endtask

    initial begin
        int  tick_at[$];
        int  t1_exp[3];
        int  t2_exp[7];
        int  gap;
        int  rel_k;
        int  acc_k;
        bit  saved_phase;
        bit  v;
        int  d;

        t1_exp = '{4, 8, 12};
        t2_exp = '{0, 1, 0, 0, 1, 0, 1};

        // Reset state
        RESETn    = 1'b0;
        run_en    = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        @(negedge CLK);
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_core_resetn", 32'(core_resetn), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_cur_div", 32'(cur_div), 32'(DEF));
        @(negedge CLK);
        RESETn = 1'b1;

        // Ticks at 4, 8, 12; core released with the 2nd tick
        for (int k = 1; k <= 12; k++) begin
            do_cycle(1'b1, 1'b0, 0);
            if (tick === 1'b1) tick_at.push_back(k);
            if (k == 7) chk("t1_core_low_c7", 32'(core_resetn), 32'd0);
            if (k == 8) chk("t1_core_high_c8", 32'(core_resetn), 32'd1);
        end
        chk("t1_ntick", 32'(tick_at.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < tick_at.size()) chk("t1_tick_cycle", 32'(tick_at[i]), 32'(t1_exp[i]));
        end

        // run_en low for 5 cycles with cnt=2
        do_cycle(1'b1, 1'b0, 0);
        saved_phase = phase;
        for (int k = 0; k < 5; k++) begin
            do_cycle(1'b0, 1'b0, 0);
            chk("t5_tick_frozen", 32'(tick), 32'd0);
            chk("t5_phase_frozen", 32'(phase), 32'(saved_phase));
        end
        for (int k = 1; k <= 3; k++) begin
            do_cycle(1'b1, 1'b0, 0);
            chk("t5_tick_after", 32'(tick), 32'(k == 3));
        end

        // cfg_div=1 accepted mid-period
        do_cycle(1'b1, 1'b0, 0);
        do_cycle(1'b1, 1'b1, 1);
        chk("t2_accepted", 32'(last_acc), 32'd1);
        for (int k = 0; k < 7; k++) begin
            do_cycle(1'b1, 1'b0, 0);
            chk("t2_tick_seq", 32'(tick), 32'(t2_exp[k]));
        end
        chk("t2_cur_div", 32'(cur_div), 32'd1);

        // cfg_div=0 clamps to 1
        offer_div(5);
        settle(5);
        offer_div(0);
        settle(1);
        measure_gap(gap);
        chk("t3_gap", 32'(gap), 32'd2);

        // Randomized run with AXI-style held requests
        v = 1'b0;
        d = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!v && $urandom_range(7) == 0) begin
                v = 1'b1;
                d = int'($urandom_range(6));
            end
            do_cycle($urandom_range(9) != 0, v, d);
            if (last_acc) v = 1'b0;
        end

        // Reset during DRAIN discards the pending divisor
        offer_div(6);
        RESETn = 1'b0;
        #1;
        model_reset();
        chk("t6_tick", 32'(tick), 32'd0);
        chk("t6_phase", 32'(phase), 32'd0);
        chk("t6_core_resetn", 32'(core_resetn), 32'd0);
        chk("t6_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("t6_cur_div", 32'(cur_div), 32'(DEF));
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;

        // cfg_valid held through HOLD; accepted on first RUN cycle
        rel_k = -1;
        acc_k = -1;
        for (int n = 0; n < 200; n++) begin
            do_cycle(1'b1, 1'b1, 2);
            if (m_released && rel_k < 0) rel_k = n;
            if (last_acc) begin
                acc_k = n;
                break;
            end
        end
        chk("t4_release_cycle", 32'(rel_k), 32'd7);
        chk("t4_accept_cycle", 32'(acc_k), 32'd8);
        settle(2);
        measure_gap(gap);
        chk("t4_gap", 32'(gap), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
